cache_fill_responder: RTL and testbench

CACHE_FILL_RESPONDER -- requirements
Module: cache_fill_responder

---
 rtl/cache_fill_responder.sv | 168 ++++++++++++++++
 tb/tb_cache_fill_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_responder.sv
// Critical-word-first 8-word line fill: fetches a line from backing memory into a
// local buffer, then streams it to the cache as 8 back-to-back words.
module cache_fill_responder #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_req,
  input  logic [31:0] sdram_addr,
  output logic        sdram_fill,
  output logic [31:0] sdram_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_q,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshakes: mem_req is held high with a stable mem_addr until mem_ack (or the
  // per-word timeout) completes that word; a word transfers on any edge where
  // mem_req && mem_ack. sdram_req is a level request accepted only in IDLE and
  // answered by a fixed 8-beat burst (sdram_fill marks beat 0).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    STREAM = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [26:0] base, base_d;
  logic [2:0]  start, start_d;
  logic [2:0]  idx, idx_d;
  logic [15:0] cnt, cnt_d;
  logic        sdram_fill_d, mem_req_d, busy_d, err_d;
  logic [31:0] sdram_data_d, mem_addr_d;
  logic [31:0] line_buf [8];
  logic        buf_we;
  logic [31:0] buf_wdata;
  logic        accept;
  logic [2:0]  next_word;

  assign state_dbg = state;
  // A word completes on ack, or when its wait has lasted TIMEOUT cycles.
  assign accept    = mem_ack || (cnt == TO_LAST);
  assign next_word = start + idx + 3'd1;

  always_comb begin
    state_d      = state;
    base_d       = base;
    start_d      = start;
    idx_d        = idx;
    cnt_d        = cnt;
    sdram_fill_d = 1'b0;
    sdram_data_d = sdram_data;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    busy_d       = busy;
    err_d        = err;
    buf_we       = 1'b0;
    buf_wdata    = mem_q;
    case (state)
      IDLE: begin
        idx_d = 3'd0;
        cnt_d = 16'd0;
        if (sdram_req) begin
          base_d     = sdram_addr[31:5];
          start_d    = sdram_addr[4:2];
          mem_req_d  = 1'b1;
          mem_addr_d = {sdram_addr[31:2], 2'b00};
          busy_d     = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (accept && !mem_ack) err_d = 1'b1;
        if (!sdram_req) begin
          // Abort: an access completing this very edge needs no drain.
          if (accept) begin
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            cnt_d     = 16'd0;
            state_d   = IDLE;
          end else begin
            cnt_d   = cnt + 16'd1;
            state_d = DRAIN;
          end
        end else if (accept) begin
          buf_we    = 1'b1;
          buf_wdata = mem_ack ? mem_q : 32'hFFFF_FFFF;
          cnt_d     = 16'd0;
          if (idx == 3'd7) begin
            mem_req_d    = 1'b0;
            idx_d        = 3'd0;
            sdram_fill_d = 1'b1;
            sdram_data_d = line_buf[0];
            state_d      = STREAM;
          end else begin
            idx_d      = idx + 3'd1;
            mem_addr_d = {base, next_word, 2'b00};
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      DRAIN: begin
        if (accept) begin
          if (!mem_ack) err_d = 1'b1;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          cnt_d     = 16'd0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      STREAM: begin
        if (idx == 3'd7) begin
          busy_d  = 1'b0;
          idx_d   = 3'd0;
          state_d = IDLE;
        end else begin
          idx_d        = idx + 3'd1;
          sdram_data_d = line_buf[idx + 3'd1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      base       <= 27'd0;
      start      <= 3'd0;
      idx        <= 3'd0;
      cnt        <= 16'd0;
      sdram_fill <= 1'b0;
      sdram_data <= 32'd0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'd0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      base       <= base_d;
      start      <= start_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      sdram_fill <= sdram_fill_d;
      sdram_data <= sdram_data_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

  // Line buffer holds no reset value; every slot is written before it streams.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[idx] <= buf_wdata;
  end

endmodule

// File: tb/tb_cache_fill_responder.sv
// Bench for cache_fill_responder: directed fills plus randomized fills against a
// transaction-level model of address order, per-word latency/timeout and burst data.
module tb_cache_fill_responder;

  localparam int TO    = 16;
  localparam int NEVER = -1;

  logic        clk = 1'b0;
  logic        reset;
  logic        sdram_req;
  logic [31:0] sdram_addr;
  logic        sdram_fill;
  logic [31:0] sdram_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_q;
  logic        busy;
  logic        err;
  logic [1:0]  state_dbg;

  cache_fill_responder #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_fill (sdram_fill),
    .sdram_data (sdram_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_q      (mem_q),
    .busy       (busy),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_err;
  logic [31:0] last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12)       return $urandom_range(0, 4);
    else if (r < 15)  return TO - 1;
    else if (r < 18)  return TO - 2;
    else if (r == 18) return $urandom_range(5, 10);
    else              return NEVER;
  endfunction

  // Drives one request and plays the memory. Word w lives at line offset
  // (start+w) mod 8 and is acked on the (lat[w]+1)-th cycle its address is shown;
  // if that would exceed TO cycles, it times out on cycle TO and reads as all ones.
  task automatic run_fill(input logic [31:0] addr, input logic [31:0] salt,
                          input int lat[8], input int abort_at, input int reset_at);
    logic [31:0] exp_addr;
    logic [31:0] d;
    int          k;
    int          drop_at;
    bit          done, is_ack, is_to, abort_now;
    sdram_addr = addr;
    sdram_req  = 1'b1;
    mem_ack    = 1'b0;
    step();
    sdram_addr = $urandom();
    check("busy_rise", 32'(busy), 32'd1);
    check("fill_idle", 32'(sdram_fill), 32'd0);
    for (int w = 0; w < 8; w++) begin
      exp_addr = {addr[31:5], 3'(addr[4:2] + w), 2'b00};
      check("mem_addr", mem_addr, exp_addr);
      check("mem_req_on", 32'(mem_req), 32'd1);
      k    = 1;
      done = 1'b0;
      is_ack = 1'b0;
      is_to  = 1'b0;
      while (!done) begin
        abort_now = (w == abort_at) && (k == 1);
        if (abort_now) sdram_req = 1'b0;
        is_ack  = (lat[w] >= 0) && (k == lat[w] + 1) && (k <= TO) && !abort_now;
        is_to   = !is_ack && (k == TO);
        mem_ack = is_ack;
        mem_q   = is_ack ? (exp_addr ^ salt) : $urandom();
        step();
        mem_ack = 1'b0;
        if (is_ack || is_to) begin
          done = 1'b1;
        end else begin
          k++;
          check("wait_mem_req", 32'(mem_req), 32'd1);
          check("wait_busy", 32'(busy), 32'd1);
          check("wait_fill", 32'(sdram_fill), 32'd0);
          check("wait_addr_hold", mem_addr, exp_addr);
        end
      end
      if (is_to) exp_err = 1'b1;
      if (w == abort_at) begin
        exp_q.delete();
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fill", 32'(sdram_fill), 32'd0);
        check("abort_data_hold", sdram_data, last_data);
        check("abort_err", 32'(err), 32'(exp_err));
        return;
      end
      exp_q.push_back(is_ack ? (exp_addr ^ salt) : 32'hFFFF_FFFF);
    end
    drop_at = $urandom_range(0, 7);
    for (int c = 0; c < 8; c++) begin
      d = exp_q.pop_front();
      check("stream_fill", 32'(sdram_fill), (c == 0) ? 32'd1 : 32'd0);
      check("stream_data", sdram_data, d);
      check("stream_busy", 32'(busy), 32'd1);
      check("stream_mem_req", 32'(mem_req), 32'd0);
      if (c == 0) check("stream_err", 32'(err), 32'(exp_err));
      last_data = d;
      if (c == drop_at) sdram_req = 1'b0;
      if (c == reset_at) begin
        reset     = 1'b0;
        sdram_req = 1'b0;
        step();
        reset     = 1'b1;
        exp_q.delete();
        exp_err   = 1'b0;
        last_data = 32'd0;
        check("rst_fill", 32'(sdram_fill), 32'd0);
        check("rst_data", sdram_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (3) begin
          step();
          check("rst_no_words", 32'(sdram_fill), 32'd0);
          check("rst_stay_idle", 32'(busy), 32'd0);
        end
        return;
      end
      step();
    end
    check("end_busy", 32'(busy), 32'd0);
    check("end_fill", 32'(sdram_fill), 32'd0);
    check("end_data_hold", sdram_data, last_data);
    check("end_err", 32'(err), 32'(exp_err));
  endtask

  int lat[8];

  initial begin
    reset      = 1'b0;
    sdram_req  = 1'b0;
    sdram_addr = 32'd0;
    mem_ack    = 1'b0;
    mem_q      = 32'd0;
    exp_err    = 1'b0;
    last_data  = 32'd0;
    repeat (2) step();
    reset = 1'b1;
    check("reset_fill", 32'(sdram_fill), 32'd0);
    check("reset_data", sdram_data, 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    repeat (5) begin
      step();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_mem_req", 32'(mem_req), 32'd0);
    end

    // zero-wait memory returning its own address
    foreach (lat[i]) lat[i] = 0;
    run_fill(32'h0000_1014, 32'd0, lat, -1, -1);
    // three wait cycles per word
    foreach (lat[i]) lat[i] = 3;
    run_fill(32'h0000_1014, 32'd0, lat, -1, -1);
    // ack lands on the timeout cycle itself, and one cycle before it
    foreach (lat[i]) lat[i] = (i % 2 == 0) ? TO - 1 : TO - 2;
    run_fill(32'hABCD_EF08, 32'h5A5A_0000, lat, -1, -1);
    // word 2 never acknowledged
    foreach (lat[i]) lat[i] = 0;
    lat[2] = NEVER;
    run_fill(32'h0000_1014, 32'd0, lat, -1, -1);
    // abort after three acks, then a clean fill
    foreach (lat[i]) lat[i] = 1;
    lat[3] = 2;
    run_fill(32'h0000_1014, 32'd0, lat, 3, -1);
    foreach (lat[i]) lat[i] = 0;
    run_fill(32'h0000_2000, 32'd0, lat, -1, -1);
    // reset in stream cycle 3
    foreach (lat[i]) lat[i] = 1;
    run_fill(32'h0000_3018, 32'h1111_2222, lat, -1, 3);

    for (int t = 0; t < 30; t++) begin
      int ab;
      foreach (lat[i]) lat[i] = rand_lat();
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      if (ab >= 0) lat[ab] = $urandom_range(1, 6);
      run_fill({$urandom()} & 32'hFFFF_FFFC, $urandom(), lat, ab, -1);
      repeat ($urandom_range(0, 3)) begin
        step();
        check("gap_busy", 32'(busy), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
